// File: rtl/rx_frame_controller.sv
// rx_frame_controller: hunts for a HEADER word, collects FRAME_LEN payload words and
// presents them on a valid/ready handshake. Optional checksum word: RX_FRAME_CHECKSUM_EN.
module rx_frame_controller #(
  parameter int                N_BITS         = 8,
  parameter int                FRAME_LEN      = 4,
  parameter logic [N_BITS-1:0] HEADER         = 8'hAA,
  parameter int                TIMEOUT_CYCLES = 104166
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx_fim,
  input  logic [N_BITS-1:0]             rx_data,
  input  logic                          rx_parity_ok,
  input  logic                          frame_ready,
  output logic                          frame_valid,
  output logic [FRAME_LEN*N_BITS-1:0]   frame_data,
  output logic                          busy,
  output logic                          err_parity,
  output logic                          err_timeout,
  output logic                          err_overrun
`ifdef RX_FRAME_CHECKSUM_EN
  ,
  output logic                          err_checksum
`endif
);

  // state   | meaning
  // IDLE    | hunting for HEADER, other words dropped
  // COLLECT | storing payload (then checksum) words, inter-word timer running
  // HOLD    | frame_valid high, frame_data frozen until frame_ready

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
`ifdef RX_FRAME_CHECKSUM_EN
  localparam logic [CNT_W-1:0] CSUM_IDX = CNT_W'(FRAME_LEN);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [TMR_W-1:0]  tmr_q;

  logic              word_ok;
  logic              word_bad;
  logic              is_header;
  logic              tmr_done;
  logic              start_frame;
  logic              store_word;
  logic              evt_parity;
  logic              evt_timeout;
  logic              evt_overrun;
`ifdef RX_FRAME_CHECKSUM_EN
  logic [N_BITS-1:0] csum_q;
  logic              evt_checksum;
`endif

  assign word_ok   = rx_fim & rx_parity_ok;
  assign word_bad  = rx_fim & ~rx_parity_ok;
  assign is_header = (rx_data == HEADER);
  // Down-counter reaches zero on the TIMEOUT_CYCLES-th word-free cycle.
  assign tmr_done  = (tmr_q == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    store_word  = 1'b0;
    evt_parity  = 1'b0;
    evt_timeout = 1'b0;
    evt_overrun = 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
    evt_checksum = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (word_ok && is_header) begin
          state_d     = COLLECT;
          start_frame = 1'b1;
        end else if (word_bad) begin
          evt_parity = 1'b1;
        end
      end
      COLLECT: begin
        if (word_bad) begin
          evt_parity = 1'b1;
          state_d    = IDLE;
        end else if (word_ok) begin
`ifdef RX_FRAME_CHECKSUM_EN
          if (cnt_q == CSUM_IDX) begin
            if (rx_data == csum_q) begin
              state_d = HOLD;
            end else begin
              evt_checksum = 1'b1;
              state_d      = IDLE;
            end
          end else begin
            store_word = 1'b1;
          end
`else
          store_word = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = HOLD;
          end
`endif
        end else if (tmr_done) begin
          evt_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      HOLD: begin
        // A word arriving with the transfer is judged as if already in IDLE.
        if (frame_ready) begin
          state_d = IDLE;
          if (word_ok && is_header) begin
            state_d     = COLLECT;
            start_frame = 1'b1;
          end else if (word_bad) begin
            evt_parity = 1'b1;
          end
        end else if (rx_fim) begin
          evt_overrun = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_valid = (state_q == HOLD);
    busy        = (state_q != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
      err_checksum <= 1'b0;
`endif
    end else begin
      err_parity  <= evt_parity;
      err_timeout <= evt_timeout;
      err_overrun <= evt_overrun;
`ifdef RX_FRAME_CHECKSUM_EN
      err_checksum <= evt_checksum;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      tmr_q      <= '0;
      frame_data <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else if (start_frame) begin
      cnt_q  <= '0;
      tmr_q  <= TMR_LOAD;
`ifdef RX_FRAME_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else if (state_q == COLLECT) begin
      if (rx_fim) begin
        tmr_q <= TMR_LOAD;
      end else if (!tmr_done) begin
        tmr_q <= tmr_q - TMR_W'(1);
      end
      if (store_word) begin
        cnt_q <= cnt_q + CNT_W'(1);
`ifdef RX_FRAME_CHECKSUM_EN
        csum_q <= csum_q ^ rx_data;
`endif
        for (int i = 0; i < FRAME_LEN; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            frame_data[i*N_BITS +: N_BITS] <= rx_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_controller.sv
// Scoreboard bench for rx_frame_controller: a word-level reference model predicts frames
// and error pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_rx_frame_controller;

  localparam int NB  = 8;
  localparam int FL  = 4;
  localparam int T   = 100;
  localparam int FW  = FL * NB;
  localparam logic [NB-1:0] HDR = 8'hAA;

  localparam int EV_FRAME = 0;
  localparam int EV_PAR   = 1;
  localparam int EV_TMO   = 2;
  localparam int EV_OVR   = 3;
  localparam int EV_CSUM  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rx_fim = 1'b0;
  logic [NB-1:0] rx_data = '0;
  logic          rx_parity_ok = 1'b0;
  logic          frame_ready = 1'b0;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic          busy;
  logic          err_parity;
  logic          err_timeout;
  logic          err_overrun;
`ifdef RX_FRAME_CHECKSUM_EN
  logic          err_checksum;
`endif

  rx_frame_controller #(
    .N_BITS(NB), .FRAME_LEN(FL), .HEADER(HDR), .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock), .reset(reset), .rx_fim(rx_fim), .rx_data(rx_data),
    .rx_parity_ok(rx_parity_ok), .frame_ready(frame_ready),
    .frame_valid(frame_valid), .frame_data(frame_data), .busy(busy),
    .err_parity(err_parity), .err_timeout(err_timeout), .err_overrun(err_overrun)
`ifdef RX_FRAME_CHECKSUM_EN
    , .err_checksum(err_checksum)
`endif
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    int            kind;
    logic [FW-1:0] data;
  } ev_t;

  ev_t           exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;
  int            ready_mode = 1;
  bit            exp_valid = 1'b0;
  bit            exp_busy = 1'b0;
  logic [FW-1:0] exp_frame = '0;

  // Reference model: words are appended to a payload queue; a timeout is simply
  // "T cycles passed since the last word" while a frame is open.
  bit            m_collect = 1'b0;
  bit            m_hold = 1'b0;
  logic [NB-1:0] m_pay[$];
  logic [FW-1:0] m_frame = '0;
  int            m_idle = 0;

  task automatic check(string name, logic [FW-1:0] act, logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(int kind, logic [FW-1:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic logic [NB-1:0] pay_xor();
    logic [NB-1:0] x = '0;
    foreach (m_pay[i]) x ^= m_pay[i];
    return x;
  endfunction

  function automatic void finish_frame();
    m_frame = '0;
    foreach (m_pay[i]) m_frame[i*NB +: NB] = m_pay[i];
    m_collect = 1'b0;
    m_hold = 1'b1;
  endfunction

  function automatic void idle_word(logic [NB-1:0] d, bit par);
    if (par && d == HDR) begin
      m_collect = 1'b1;
      m_pay.delete();
      m_idle = 0;
    end else if (!par) begin
      push(EV_PAR, '0);
    end
  endfunction

  function automatic void model_step(bit fim, logic [NB-1:0] d, bit par, bit rdy);
    if (m_hold) begin
      if (rdy) begin
        push(EV_FRAME, m_frame);
        m_hold = 1'b0;
        if (fim) idle_word(d, par);
      end else if (fim) begin
        push(EV_OVR, '0);
      end
    end else if (m_collect) begin
      if (fim) begin
        m_idle = 0;
        if (!par) begin
          push(EV_PAR, '0);
          m_collect = 1'b0;
        end else if (m_pay.size() < FL) begin
          m_pay.push_back(d);
`ifndef RX_FRAME_CHECKSUM_EN
          if (m_pay.size() == FL) finish_frame();
`endif
        end
`ifdef RX_FRAME_CHECKSUM_EN
        else if (d == pay_xor()) begin
          finish_frame();
        end else begin
          push(EV_CSUM, '0);
          m_collect = 1'b0;
        end
`endif
      end else begin
        m_idle++;
        if (m_idle >= T) begin
          push(EV_TMO, '0);
          m_collect = 1'b0;
        end
      end
    end else if (fim) begin
      idle_word(d, par);
    end
  endfunction

  // Drives one cycle's inputs (at posedge+1), advances the model, ends at the next posedge+1.
  task automatic cycle(bit fim, logic [NB-1:0] d, bit par);
    bit rdy;
    case (ready_mode)
      0: rdy = 1'b0;
      1: rdy = 1'b1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    rx_fim       = fim;
    rx_data      = fim ? d : NB'($urandom);
    rx_parity_ok = fim ? par : 1'($urandom);
    frame_ready  = rdy;
    exp_valid    = m_hold;
    exp_busy     = m_collect | m_hold;
    exp_frame    = m_frame;
    model_step(fim, d, par, rdy);
    @(posedge clock);
    #1;
  endtask

  task automatic send(logic [NB-1:0] d, bit par, int gap);
    repeat (gap - 1) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, d, par);
  endtask

  task automatic send_frame(logic [FW-1:0] p);
    logic [NB-1:0] x = '0;
    send(HDR, 1'b1, 1);
    for (int i = 0; i < FL; i++) begin
      send(p[i*NB +: NB], 1'b1, 1);
      x ^= p[i*NB +: NB];
    end
`ifdef RX_FRAME_CHECKSUM_EN
    send(x, 1'b1, 1);
`endif
  endtask

  task automatic take(string name, int kind, logic [FW-1:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, FW'(1), FW'(0));
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, FW'(kind), FW'(e.kind));
      if (kind == EV_FRAME) check("frame_payload", data, e.data);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      check("frame_valid", FW'(frame_valid), FW'(exp_valid));
      check("busy", FW'(busy), FW'(exp_busy));
      if (exp_valid) check("held_data", frame_data, exp_frame);
      if (err_parity)  take("err_parity", EV_PAR, '0);
      if (err_timeout) take("err_timeout", EV_TMO, '0);
      if (err_overrun) take("err_overrun", EV_OVR, '0);
`ifdef RX_FRAME_CHECKSUM_EN
      if (err_checksum) take("err_checksum", EV_CSUM, '0);
`endif
      if (frame_valid && frame_ready) take("frame", EV_FRAME, frame_data);
    end
  end

  task automatic check_quiet(string name);
    check({name, "_valid"}, FW'(frame_valid), FW'(0));
    check({name, "_busy"}, FW'(busy), FW'(0));
    check({name, "_data"}, frame_data, FW'(0));
    check({name, "_errs"}, FW'({err_parity, err_timeout, err_overrun}), FW'(0));
  endtask

  initial begin
    int            gap;
    logic [NB-1:0] d;
    bit            par;

    repeat (3) @(posedge clock);
    #1;
    check_quiet("reset");
    reset = 1'b1;
    mon_en = 1'b1;
    ready_mode = 1;

    // nominal frame, single-cycle hold with ready high
    send_frame(32'h44332211);
    check("nominal_valid", FW'(frame_valid), FW'(1));
    check("nominal_data", frame_data, 32'h44332211);
    repeat (2) cycle(1'b0, '0, 1'b1);

    // header hunt
    send(8'h55, 1'b1, 1);
    check("hunt_busy", FW'(busy), FW'(0));
    send_frame(32'h04030201);
    check("hunt_data", frame_data, 32'h04030201);
    repeat (2) cycle(1'b0, '0, 1'b1);

    // parity abort mid-frame
    send(HDR, 1'b1, 1);
    send(8'h11, 1'b1, 1);
    send(8'h22, 1'b0, 1);
    check("parity_pulse", FW'(err_parity), FW'(1));
    check("parity_busy", FW'(busy), FW'(0));
    send_frame(32'h04030201);
    check("parity_next_data", frame_data, 32'h04030201);
    repeat (2) cycle(1'b0, '0, 1'b1);

    // timeout after T idle cycles
    send(HDR, 1'b1, 1);
    send(8'h11, 1'b1, 1);
    repeat (T) cycle(1'b0, '0, 1'b1);
    check("timeout_pulse", FW'(err_timeout), FW'(1));
    check("timeout_busy", FW'(busy), FW'(0));
    send_frame(32'h04030201);
    repeat (2) cycle(1'b0, '0, 1'b1);

    // word on the expiry cycle wins over the timeout
    send(HDR, 1'b1, 1);
    send(8'h11, 1'b1, 1);
    send(8'h22, 1'b1, T);
    check("expiry_fim_busy", FW'(busy), FW'(1));
    check("expiry_fim_no_tmo", FW'(err_timeout), FW'(0));
    send(8'h33, 1'b1, 1);
    send(8'h44, 1'b1, 1);
`ifdef RX_FRAME_CHECKSUM_EN
    send(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1'b1, 1);
`endif
    check("expiry_fim_valid", FW'(frame_valid), FW'(1));
    repeat (2) cycle(1'b0, '0, 1'b1);

    // one cycle too late: timeout, late word dropped in IDLE
    send(HDR, 1'b1, 1);
    send(8'h11, 1'b1, T + 1);
    check("late_fim_busy", FW'(busy), FW'(0));
    repeat (2) cycle(1'b0, '0, 1'b1);

    // overrun under backpressure, then header arriving with the transfer
    ready_mode = 0;
    send_frame(32'h44332211);
    send(8'h77, 1'b1, 2);
    check("overrun_pulse", FW'(err_overrun), FW'(1));
    check("overrun_data", frame_data, 32'h44332211);
    ready_mode = 1;
    send(HDR, 1'b1, 1);
    check("handoff_busy", FW'(busy), FW'(1));
    check("handoff_valid", FW'(frame_valid), FW'(0));
    for (int i = 1; i <= FL; i++) send(NB'(i), 1'b1, 1);
`ifdef RX_FRAME_CHECKSUM_EN
    send(8'h04, 1'b1, 1);
`endif
    check("handoff_data", frame_data, 32'h04030201);
    repeat (2) cycle(1'b0, '0, 1'b1);

    // asynchronous reset mid-frame
    send(HDR, 1'b1, 1);
    send(8'h11, 1'b1, 1);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check_quiet("async_reset");
    m_collect = 1'b0;
    m_hold = 1'b0;
    exp_q.delete();
    repeat (2) cycle(1'b0, '0, 1'b1);
    reset = 1'b1;
    mon_en = 1'b1;
    send_frame(32'h04030201);
    check("post_reset_data", frame_data, 32'h04030201);
    repeat (2) cycle(1'b0, '0, 1'b1);

`ifdef RX_FRAME_CHECKSUM_EN
    send(HDR, 1'b1, 1);
    for (int i = 1; i <= FL; i++) send(NB'(i), 1'b1, 1);
    send(8'h05, 1'b1, 1);
    check("csum_pulse", FW'(err_checksum), FW'(1));
    check("csum_busy", FW'(busy), FW'(0));
    repeat (2) cycle(1'b0, '0, 1'b1);
`endif

    // randomized traffic with random backpressure
    ready_mode = 2;
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) gap = T - 1 + int'($urandom_range(0, 3));
      else gap = int'($urandom_range(1, 4));
      d   = ($urandom_range(0, 9) < 3) ? HDR : NB'($urandom);
      par = ($urandom_range(0, 19) != 0);
      send(d, par, gap);
    end

    ready_mode = 1;
    repeat (T + 5) cycle(1'b0, '0, 1'b1);
    check("pending_events", FW'(exp_q.size()), FW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
